dht11_read_scheduler: RTL and testbench

Transaction controller for the DHT11 single-wire sensor path. It sequences one complete read: trigger the start-signal unit, wait for the sensor-response confirmation, arm the 40-bit frame receiver, then validate the checksum. It also enforces the sensor's minimum inter-read interval, retries failed reads, and publishes registered measurement results to the host logic. It sits between host/user logic and the start-signal and bit-receiver units that share the single data pin.

---
 rtl/dht11_pkg.sv | 26 ++
 rtl/dht11_read_scheduler_if.sv | 16 +
 rtl/dht11_interval_timer.sv | 19 +
 rtl/dht11_read_scheduler.sv | 104 ++++++++++
 tb/tb_dht11_read_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared states, frame field positions, default timing and checksum helper
package dht11_pkg;
  localparam int CYCLES_PER_MS = 1000;
  localparam int DEF_MIN_INTERVAL_CYC = 2000 * CYCLES_PER_MS;
  localparam int DEF_ACK_TIMEOUT_CYC = 20 * CYCLES_PER_MS;
  localparam int DEF_FRAME_TIMEOUT_CYC = 6 * CYCLES_PER_MS;
  localparam int DEF_MAX_RETRIES = 3;
  localparam int DEF_RETRY_GAP_CYC = 2000 * CYCLES_PER_MS;
  localparam int DEF_AUTO_PERIOD_CYC = 4000 * CYCLES_PER_MS;
  localparam int HUM_INT_LSB = 32;
  localparam int HUM_DEC_LSB = 24;
  localparam int TEMP_INT_LSB = 16;
  localparam int TEMP_DEC_LSB = 8;
  localparam int CSUM_LSB = 0;
  typedef enum logic [3:0] {
    COOLDOWN, IDLE, START, WAIT_ACK, RECEIVE, CHECK, FAILCHK, RETRY_WAIT, DONE
  } state_t;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic logic checksum_ok(input logic [39:0] f);
    logic [7:0] s;
    s = f[HUM_INT_LSB +: 8] + f[HUM_DEC_LSB +: 8] + f[TEMP_INT_LSB +: 8] + f[TEMP_DEC_LSB +: 8];
    return s == f[CSUM_LSB +: 8];
  endfunction
endpackage

// File: rtl/dht11_read_scheduler_if.sv
// dht11_read_scheduler_if: host and sensor-path signals of the read scheduler
interface dht11_read_scheduler_if;
  logic enable, host_req, busy, start_go, start_done, rx_arm, rx_frame_valid, rx_error;
  logic data_valid, err_checksum, err_timeout, read_fail;
  logic [39:0] rx_frame;
  logic [15:0] humidity, temperature;
  logic [1:0] attempt;
  modport master (
    output enable, host_req, start_done, rx_frame_valid, rx_error, rx_frame,
    input busy, start_go, rx_arm, data_valid, humidity, temperature, err_checksum, err_timeout, read_fail, attempt
  );
  modport slave (
    input enable, host_req, start_done, rx_frame_valid, rx_error, rx_frame,
    output busy, start_go, rx_arm, data_valid, humidity, temperature, err_checksum, err_timeout, read_fail, attempt
  );
endinterface

// File: rtl/dht11_interval_timer.sv
// dht11_interval_timer: loadable down-counter with a zero-reached done flag
module dht11_interval_timer #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  // reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/dht11_read_scheduler.sv
// dht11_read_scheduler: DHT11 read transaction controller; define DHT11_AUTO_POLL_EN for periodic self-triggered reads
module dht11_read_scheduler
  import dht11_pkg::*;
#(
  parameter int MIN_INTERVAL_CYC = DEF_MIN_INTERVAL_CYC,
  parameter int ACK_TIMEOUT_CYC = DEF_ACK_TIMEOUT_CYC,
  parameter int FRAME_TIMEOUT_CYC = DEF_FRAME_TIMEOUT_CYC,
  parameter int MAX_RETRIES = DEF_MAX_RETRIES,
  parameter int RETRY_GAP_CYC = DEF_RETRY_GAP_CYC
`ifdef DHT11_AUTO_POLL_EN
  , parameter int AUTO_PERIOD_CYC = DEF_AUTO_PERIOD_CYC
`endif
) (
  input logic clk,
  input logic rst,
  dht11_read_scheduler_if.slave bus
);
  localparam int GAP_CYC = max_i(RETRY_GAP_CYC, MIN_INTERVAL_CYC);
  localparam int TW = $clog2(max_i(max_i(GAP_CYC, ACK_TIMEOUT_CYC), FRAME_TIMEOUT_CYC)) + 1;
  state_t state, nxt;
  logic req, pending, sd_q, sd_rise, accept, ck_ok, t_done, t_load;
  logic dv, rf, e_cs, e_to;
  logic [TW-1:0] t_val;
  logic [39:0] frame_q;
  logic [15:0] hum, temp;
  logic [1:0] att;
`ifdef DHT11_AUTO_POLL_EN
  localparam int PW = $clog2(AUTO_PERIOD_CYC) + 1;
  logic [PW-1:0] per;
  // free-running poll period, paused while disabled
  always_ff @(posedge clk or posedge rst)
    if (rst) per <= '0;
    else if (bus.enable) per <= per == PW'(AUTO_PERIOD_CYC - 1) ? '0 : per + 1'b1;
  assign req = bus.host_req || (bus.enable && per == PW'(AUTO_PERIOD_CYC - 1));
`else
  assign req = bus.host_req;
`endif
  assign sd_rise = bus.start_done && !sd_q;
  assign ck_ok = checksum_ok(frame_q);
  assign accept = state == IDLE && nxt == START;
  assign t_load = nxt != state;
  assign t_val = nxt == COOLDOWN ? TW'(MIN_INTERVAL_CYC - 1) :
                 nxt == WAIT_ACK ? TW'(ACK_TIMEOUT_CYC - 1) :
                 nxt == RECEIVE ? TW'(FRAME_TIMEOUT_CYC - 1) :
                 nxt == RETRY_WAIT ? TW'(GAP_CYC - 1) : '0;
  dht11_interval_timer #(.W(TW), .RST_VAL(TW'(MIN_INTERVAL_CYC - 1))) u_timer (
    .clk(clk), .rst(rst), .load(t_load), .load_val(t_val), .done(t_done)
  );
  // next-state: the shared timer is reloaded on every state change
  always_comb begin
    nxt = state;
    case (state)
      COOLDOWN:   nxt = t_done ? IDLE : COOLDOWN;
      IDLE:       nxt = bus.enable && (req || pending) ? START : IDLE;
      START:      nxt = WAIT_ACK;
      WAIT_ACK:   nxt = sd_rise ? RECEIVE : t_done ? FAILCHK : WAIT_ACK;
      RECEIVE:    nxt = bus.rx_frame_valid ? CHECK : (bus.rx_error || t_done) ? FAILCHK : RECEIVE;
      CHECK:      nxt = ck_ok ? DONE : FAILCHK;
      FAILCHK:    nxt = 32'(att) < MAX_RETRIES ? RETRY_WAIT : DONE;
      RETRY_WAIT: nxt = !bus.enable ? DONE : t_done ? START : RETRY_WAIT;
      DONE:       nxt = COOLDOWN;
      default:    nxt = COOLDOWN;
    endcase
  end
  // state, request queue, frame capture and registered results
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= COOLDOWN;
      pending <= 1'b0;
      sd_q <= 1'b0;
      frame_q <= '0;
      dv <= 1'b0;
      rf <= 1'b0;
      e_cs <= 1'b0;
      e_to <= 1'b0;
      hum <= '0;
      temp <= '0;
      att <= '0;
    end else begin
      state <= nxt;
      pending <= !accept && (pending || req);
      sd_q <= bus.start_done;
      if (state == RECEIVE && bus.rx_frame_valid) frame_q <= bus.rx_frame;
      dv <= state == CHECK && ck_ok;
      rf <= state == FAILCHK && nxt == DONE;
      e_cs <= !accept && (e_cs || (state == CHECK && !ck_ok));
      e_to <= !accept && (e_to || ((state == WAIT_ACK || state == RECEIVE) && nxt == FAILCHK));
      att <= accept ? 2'd0 : att + 2'(state == FAILCHK && nxt == RETRY_WAIT);
      if (state == CHECK && ck_ok) begin
        hum <= frame_q[HUM_DEC_LSB +: 16];
        temp <= frame_q[TEMP_DEC_LSB +: 16];
      end
    end
  assign bus.busy = !(state == COOLDOWN || state == IDLE);
  assign bus.start_go = state == START;
  assign bus.rx_arm = state == RECEIVE;
  assign bus.data_valid = dv;
  assign bus.read_fail = rf;
  assign bus.err_checksum = e_cs;
  assign bus.err_timeout = e_to;
  assign bus.humidity = hum;
  assign bus.temperature = temp;
  assign bus.attempt = att;
endmodule

// File: tb/tb_dht11_read_scheduler.sv
// tb_dht11_read_scheduler: randomized transaction bench against an outcome-level reference model
module tb_dht11_read_scheduler;
  localparam int MIN = 100, ACK = 50, FRM = 80, GAP = 100, RETR = 3;
  localparam int K_NOACK = 0, K_RXERR = 1, K_NOFRM = 2, K_FRAME = 3;
  localparam logic [39:0] GOOD = 40'h350018004D, BAD = 40'h350018004E, JUNK = 40'h0101010104;
  logic clk = 0, rst = 1;
  int cyc = 0, n_cmp = 0, n_bad = 0, dv_cnt = 0, rf_cnt = 0, sg_cnt = 0, last_sg = 0;
  logic [15:0] exp_hum = '0, exp_temp = '0;
  int plan_k[4];
  logic [39:0] plan_f[4];
  dht11_read_scheduler_if bus();
  dht11_read_scheduler #(
    .MIN_INTERVAL_CYC(MIN), .ACK_TIMEOUT_CYC(ACK), .FRAME_TIMEOUT_CYC(FRM),
    .MAX_RETRIES(RETR), .RETRY_GAP_CYC(GAP)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      dv_cnt <= dv_cnt + int'(bus.data_valid);
      rf_cnt <= rf_cnt + int'(bus.read_fail);
      sg_cnt <= sg_cnt + int'(bus.start_go);
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit csum_ok(input logic [39:0] f);
    int s;
    s = 0;
    for (int b = 1; b < 5; b++) s += int'(f[8*b +: 8]);
    return (s % 256) == int'(f[7:0]);
  endfunction
  function automatic logic [39:0] rand_frame(input bit good);
    logic [31:0] r;
    int s;
    r = $urandom;
    s = int'(r[31:24]) + int'(r[23:16]) + int'(r[15:8]) + int'(r[7:0]);
    if (!good) s += int'($urandom_range(1, 255));
    return {r, 8'(s % 256)};
  endfunction
  task automatic set_all(input int k, input logic [39:0] f);
    for (int i = 0; i < 4; i++) begin
      plan_k[i] = k;
      plan_f[i] = f;
    end
  endtask
  task automatic pulse_req();
    bus.host_req = 1;
    @(negedge clk);
    bus.host_req = 0;
  endtask
  task automatic wait_sg(input int i);
    bit seen;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = bus.start_go;
    end
    check("start_go_seen", seen, 1);
    if (seen) begin
      check("start_go_spacing", (cyc - last_sg) >= MIN, 1);
      check("attempt_index", bus.attempt, i);
      last_sg = cyc;
    end
  endtask
  task automatic wait_arm(output bit ok);
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = bus.rx_arm;
    end
  endtask
  task automatic do_attempt(input int i, input int kind, input logic [39:0] f, input bit coin);
    int t0, len, d;
    bit ok, armed, ended;
    if (kind == K_NOACK) begin
      t0 = cyc;
      armed = 0;
      ended = 0;
      for (int k = 0; k < 200 && !ended; k++) begin
        @(negedge clk);
        armed |= bus.rx_arm;
        ended = int'(bus.attempt) != i || bus.read_fail;
      end
      check("ack_timeout_seen", ended, 1);
      check("ack_timeout_window", (cyc - t0) >= ACK && (cyc - t0) <= ACK + 3, 1);
      check("no_arm_without_ack", armed, 0);
      check("ack_timeout_flag", bus.err_timeout, 1);
      return;
    end
    @(negedge clk);
    bus.rx_frame = JUNK;
    bus.rx_frame_valid = 1;
    @(negedge clk);
    bus.rx_frame_valid = 0;
    repeat ($urandom_range(1, 30)) @(negedge clk);
    bus.start_done = 1;
    wait_arm(ok);
    bus.start_done = 0;
    check("rx_arm_after_ack", ok, 1);
    if (!ok) return;
    if (kind == K_NOFRM) begin
      len = 0;
      while (bus.rx_arm && len < 200) begin
        len++;
        @(negedge clk);
      end
      check("frame_timeout_len", len, FRM);
      return;
    end
    d = coin ? FRM : int'($urandom_range(1, FRM - 10));
    repeat (d - 1) @(negedge clk);
    check("rx_arm_held", bus.rx_arm, 1);
    if (kind == K_FRAME) begin
      bus.rx_frame = f;
      bus.rx_frame_valid = 1;
    end else bus.rx_error = 1;
    @(negedge clk);
    bus.rx_frame_valid = 0;
    bus.rx_error = 0;
  endtask
  task automatic run_txn(input bit issue, input bit extra, input bit coin);
    int n_used, dv0, rf0, sg0;
    bit succ, ecs, eto, idle;
    n_used = 0; succ = 0; ecs = 0; eto = 0; idle = 0;
    dv0 = dv_cnt; rf0 = rf_cnt; sg0 = sg_cnt;
    for (int i = 0; i < 4; i++) begin
      n_used = i + 1;
      if (plan_k[i] == K_FRAME && csum_ok(plan_f[i])) begin
        succ = 1;
        break;
      end
      if (plan_k[i] == K_FRAME) ecs = 1;
      else eto = 1;
    end
    if (succ) begin
      exp_hum = plan_f[n_used-1][39:24];
      exp_temp = plan_f[n_used-1][23:8];
    end
    if (issue) pulse_req();
    for (int i = 0; i < n_used; i++) begin
      wait_sg(i);
      if (extra && i == 0) begin
        pulse_req();
        pulse_req();
      end
      do_attempt(i, plan_k[i], plan_f[i], coin);
    end
    for (int k = 0; k < 300 && !idle; k++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    check("busy_released", idle, 1);
    check("start_go_count", sg_cnt - sg0, n_used);
    check("data_valid_count", dv_cnt - dv0, succ);
    check("read_fail_count", rf_cnt - rf0, !succ);
    check("err_checksum", bus.err_checksum, ecs);
    check("err_timeout", bus.err_timeout, eto);
    check("final_attempt", bus.attempt, n_used - 1);
    check("humidity", bus.humidity, exp_hum);
    check("temperature", bus.temperature, exp_temp);
  endtask
  initial begin
    int sg0, rf0;
    bit ok;
    bus.enable = 1;
    bus.host_req = 0;
    bus.start_done = 0;
    bus.rx_frame_valid = 0;
    bus.rx_error = 0;
    bus.rx_frame = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {bus.busy, bus.start_go, bus.rx_arm, bus.data_valid, bus.read_fail,
                         bus.err_checksum, bus.err_timeout, bus.attempt}, 0);
    check("reset_data", {bus.humidity, bus.temperature}, 0);
    rst = 0;
    last_sg = cyc;
    repeat (10) @(negedge clk);
    set_all(K_FRAME, GOOD);
    run_txn(1, 0, 0);
    set_all(K_FRAME, BAD);
    run_txn(1, 0, 0);
    set_all(K_FRAME, GOOD);
    plan_k[0] = K_NOACK;
    plan_k[1] = K_NOFRM;
    plan_f[2] = 40'h2A051B034D;
    run_txn(1, 0, 0);
    set_all(K_FRAME, 40'h3C00140050);
    run_txn(1, 1, 1);
    set_all(K_FRAME, 40'h2A051B034D);
    run_txn(0, 0, 0);
    sg0 = sg_cnt;
    repeat (250) @(negedge clk);
    check("single_queued_request", sg_cnt - sg0, 0);
    bus.enable = 0;
    pulse_req();
    repeat (150) @(negedge clk);
    check("enable_blocks_start", sg_cnt - sg0, 0);
    bus.enable = 1;
    set_all(K_FRAME, GOOD);
    run_txn(0, 0, 0);
    sg0 = sg_cnt;
    rf0 = rf_cnt;
    pulse_req();
    wait_sg(0);
    do_attempt(0, K_FRAME, BAD, 0);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.attempt == 2'd1;
    end
    check("retry_wait_reached", ok, 1);
    bus.enable = 0;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = !bus.busy;
    end
    check("abort_busy_released", ok, 1);
    check("abort_no_read_fail", rf_cnt - rf0, 0);
    check("abort_no_retry", sg_cnt - sg0, 1);
    check("abort_err_checksum", bus.err_checksum, 1);
    bus.enable = 1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = int'($urandom_range(0, 5));
        plan_k[i] = k > 3 ? K_FRAME : k;
        plan_f[i] = rand_frame($urandom_range(0, 1) == 1);
      end
      run_txn(1, 0, 0);
    end
    set_all(K_FRAME, GOOD);
    run_txn(1, 0, 0);
    pulse_req();
    wait_sg(0);
    repeat (5) @(negedge clk);
    bus.start_done = 1;
    wait_arm(ok);
    bus.start_done = 0;
    check("reset_case_armed", ok, 1);
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("async_rx_arm_drop", bus.rx_arm, 0);
    check("async_busy_drop", bus.busy, 0);
    check("async_reset_data", {bus.humidity, bus.temperature}, 0);
    check("async_reset_ctrl", {bus.start_go, bus.data_valid, bus.read_fail,
                               bus.err_checksum, bus.err_timeout, bus.attempt}, 0);
    @(negedge clk);
    rst = 0;
    last_sg = cyc;
    exp_hum = '0;
    exp_temp = '0;
    set_all(K_FRAME, 40'h3C00140050);
    run_txn(1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
